arbitro_turnos: RTL and testbench
=================================

Name: arbitro_turnos

Overview:
- Reads the nine 2-bit cell registers written by the cell selector.
- Detects each new move and checks that it is legal.
- Scans the 8 winning lines sequentially and generates the turno_p1/turno_p2 turn lines that gate the selector.
- Reports the winner or a draw, and holds the game until nuevo_juego.

Parameters:
- JUGADOR_INICIAL, 1: 1 = P1 (X) starts; 2 = P2 (O) starts.
- CICLOS_TURNO, 50_000_000: turn time limit in clk cycles. Used only with TIEMPO_LIMITE_EN.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- nuevo_juego  in  1  synchronous restart.
- guarda_c1..guarda_c9  in  2 each  cell codes: 00 empty, 11 P1 (X), 01 P2 (O), 10 illegal.
- turno_p1  out  1  P1 may move.
- turno_p2  out  1  P2 may move.
- ganador  out  2  00 none, 11 P1, 01 P2, 10 draw.
- juego_terminado  out  1  high in FIN.
- linea_ganadora  out  3  index of the winning line, valid when ganador is 11 or 01.
- falta  out  1  one-cycle pulse on an illegal move, or on timeout when TIEMPO_LIMITE_EN is defined.
- movimientos  out  4  count of legal moves, 0..9.

Behaviour:
- Reset (async, rst=1) forces:
  - ESPERA state; turn lines set per JUGADOR_INICIAL (e.g. turno_p1=1, turno_p2=0).
  - ganador=00, juego_terminado=0, linea_ganadora=0, falta=0, movimientos=0.
  - Internal snapshot of all nine cells = 00; line index = 0.
  - Reset mid-scan aborts the scan with no residue.
- The two turn lines are never both 1. Both are 0 in EVALUA and FIN.
- States: ESPERA, EVALUA, FIN. nuevo_juego has priority in every state: it does the reset actions, except the snapshot loads the current board.
- ESPERA:
  - A move is detected in cycle C when the current board differs from the snapshot.
  - On the edge ending C, the snapshot loads the current board.
  - The move is legal only if all three hold: exactly one cell differs, its old value was 00, and its new value is the code of the player on turn.
  - Legal move: movimientos+1, go to EVALUA with index 0; both turn lines go 0 from C+1.
  - Illegal move: falta=1 for cycle C+1 only; stay in ESPERA; turn and movimientos unchanged.
- EVALUA:
  - Tests one line per cycle, index 0..7.
  - Line order: 0:c1c2c3, 1:c4c5c6, 2:c7c8c9, 3:c1c4c7, 4:c2c5c8, 5:c3c6c9, 6:c1c5c9, 7:c3c5c7.
  - A line matches when all three snapshot cells are equal and nonzero (10 never matches).
  - First match at index k (tested in cycle C+1+k): go to FIN with ganador = cell code and linea_ganadora = k; both update at that edge. The scan ends early.
  - No match after index 7:
    - If movimientos == 9: go to FIN with ganador=10.
    - Otherwise: toggle the player and return to ESPERA; the new turn line is high from cycle C+9.
  - Board changes during EVALUA are not sampled. They are detected on return to ESPERA.
- FIN:
  - All outputs are held and board changes are ignored.
  - Only nuevo_juego or rst leaves FIN.
- A win on the 9th move reports the winner, not a draw.
- movimientos saturates at 9.

Optional Feature:
- Macro: TIEMPO_LIMITE_EN.
- Defined:
  - A turn counter (width $clog2(CICLOS_TURNO)) runs while in ESPERA.
  - It clears on any detected move (legal or illegal), on entry to ESPERA, and on nuevo_juego.
  - At CICLOS_TURNO-1, the turn passes to the other player, falta pulses for 1 cycle, movimientos is unchanged, and the counter clears.
- Not defined: no counter, no timeout logic; a turn waits indefinitely.

Decomposition:
- Package gato_pkg holds:
  - Cell code constants: VACIA=2'b00, EQUIS=2'b11, CIRCULO=2'b01.
  - Ganador constants: NINGUNO, GANA_P1, GANA_P2, EMPATE.
  - State enum: ESPERA, EVALUA, FIN.
  - Constant table LINEAS[8][3] of cell indices.
- Sub-module comparador_linea (combinational): takes three 2-bit cells, returns coincide plus the code.
- arbitro_turnos instantiates comparador_linea once and feeds it the cells muxed by the line index.

Test Plan:
- Reset, JUGADOR_INICIAL=1 -> turno_p1=1, turno_p2=0, ganador=00, movimientos=0.
- c5 set to 11 in cycle C -> both turn lines 0 over C+1..C+8; turno_p2=1 at C+9; movimientos=1; falta never high.
- P1 takes c1, c2, c3 (P2 takes c4, c5 between) -> after c3, FIN at C+2; ganador=11, linea_ganadora=0, juego_terminado=1.
- P2 on turn but c7 written as 11, or c1 and c2 changed in the same cycle -> falta high exactly one cycle; turn unchanged; movimientos unchanged.
- Nine legal moves with no line -> ganador=10 after the 9th scan completes; movimientos=9.
- rst asserted mid-EVALUA -> outputs immediately at reset values; nuevo_juego in FIN -> ESPERA, ganador=00; with TIEMPO_LIMITE_EN and CICLOS_TURNO=16, no move for 16 cycles -> falta pulse and turn swaps.

Source files
------------

// File: rtl/gato_pkg.sv
// Shared constants and types for the tic-tac-toe turn arbiter.
package gato_pkg;

    // Cell codes as written by the cell selector
    localparam logic [1:0] VACIA   = 2'b00;
    localparam logic [1:0] EQUIS   = 2'b11;
    localparam logic [1:0] CIRCULO = 2'b01;

    // Result codes; a winner reuses the winning player's cell code
    localparam logic [1:0] NINGUNO = 2'b00;
    localparam logic [1:0] GANA_P1 = 2'b11;
    localparam logic [1:0] GANA_P2 = 2'b01;
    localparam logic [1:0] EMPATE  = 2'b10;

    localparam int unsigned NUM_CELDAS = 9;
    localparam int unsigned NUM_LINEAS = 8;

    typedef enum logic [1:0] {
        ESPERA = 2'd0,
        EVALUA = 2'd1,
        FIN    = 2'd2
    } estado_t;

    // Cell indices (0-based, c1 = 0) of each winning line, in scan order
    localparam logic [3:0] LINEAS [NUM_LINEAS][3] = '{
        '{4'd0, 4'd1, 4'd2},
        '{4'd3, 4'd4, 4'd5},
        '{4'd6, 4'd7, 4'd8},
        '{4'd0, 4'd3, 4'd6},
        '{4'd1, 4'd4, 4'd7},
        '{4'd2, 4'd5, 4'd8},
        '{4'd0, 4'd4, 4'd8},
        '{4'd2, 4'd4, 4'd6}
    };

endpackage

// File: rtl/comparador_linea.sv
// Combinational check of one line: three equal cells holding a player code.
module comparador_linea
    import gato_pkg::*;
(
    input  logic [1:0] a,
    input  logic [1:0] b,
    input  logic [1:0] c,
    output logic       coincide,
    output logic [1:0] codigo
);

    // The illegal code 10 and empty cells never form a line
    assign coincide = (a == b) && (b == c) && (a != VACIA) && (a != EMPATE);
    assign codigo   = a;

endmodule

// File: rtl/arbitro_turnos.sv
// Turn arbiter: validates moves, scans the 8 lines one per cycle, reports result.
// Optional turn time limit enabled by defining TIEMPO_LIMITE_EN.
module arbitro_turnos
    import gato_pkg::*;
#(
    parameter int unsigned JUGADOR_INICIAL = 1
`ifdef TIEMPO_LIMITE_EN
    , parameter int unsigned CICLOS_TURNO  = 50_000_000
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       nuevo_juego,
    input  logic [1:0] guarda_c1,
    input  logic [1:0] guarda_c2,
    input  logic [1:0] guarda_c3,
    input  logic [1:0] guarda_c4,
    input  logic [1:0] guarda_c5,
    input  logic [1:0] guarda_c6,
    input  logic [1:0] guarda_c7,
    input  logic [1:0] guarda_c8,
    input  logic [1:0] guarda_c9,
    output logic       turno_p1,
    output logic       turno_p2,
    output logic [1:0] ganador,
    output logic       juego_terminado,
    output logic [2:0] linea_ganadora,
    output logic       falta,
    output logic [3:0] movimientos
);

    localparam logic INICIA_P1 = (JUGADOR_INICIAL != 2);

`ifdef TIEMPO_LIMITE_EN
    localparam int unsigned TW = $clog2(CICLOS_TURNO);
    logic [TW-1:0] cont_turno;
`endif

    estado_t          estado;
    logic             jugador_p1;
    logic [2:0]       indice;
    logic [8:0][1:0]  snap;
    logic [8:0][1:0]  tablero;

    logic [3:0]       n_dif;
    logic [3:0]       pos;
    logic             hay_mov;
    logic             mov_legal;
    logic [1:0]       codigo_turno;
    logic             coincide;
    logic [1:0]       codigo_linea;

    assign tablero = {guarda_c9, guarda_c8, guarda_c7, guarda_c6, guarda_c5,
                      guarda_c4, guarda_c3, guarda_c2, guarda_c1};

    // Count cells that differ from the snapshot and remember the last one
    always_comb begin
        n_dif = '0;
        pos   = '0;
        for (int i = 0; i < int'(NUM_CELDAS); i++) begin
            if (tablero[i] != snap[i]) begin
                n_dif = n_dif + 4'd1;
                pos   = 4'(i);
            end
        end
    end

    assign codigo_turno = jugador_p1 ? EQUIS : CIRCULO;
    assign hay_mov      = (n_dif != 4'd0);
    assign mov_legal    = (n_dif == 4'd1) && (snap[pos] == VACIA) &&
                          (tablero[pos] == codigo_turno);

    comparador_linea u_comparador (
        .a        (snap[LINEAS[indice][0]]),
        .b        (snap[LINEAS[indice][1]]),
        .c        (snap[LINEAS[indice][2]]),
        .coincide (coincide),
        .codigo   (codigo_linea)
    );

    // Game FSM with registered outputs; nuevo_juego overrides every state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado          <= ESPERA;
            jugador_p1      <= INICIA_P1;
            turno_p1        <= INICIA_P1;
            turno_p2        <= !INICIA_P1;
            ganador         <= NINGUNO;
            juego_terminado <= 1'b0;
            linea_ganadora  <= '0;
            falta           <= 1'b0;
            movimientos     <= '0;
            indice          <= '0;
            snap            <= '0;
`ifdef TIEMPO_LIMITE_EN
            cont_turno      <= '0;
`endif
        end else if (nuevo_juego) begin
            estado          <= ESPERA;
            jugador_p1      <= INICIA_P1;
            turno_p1        <= INICIA_P1;
            turno_p2        <= !INICIA_P1;
            ganador         <= NINGUNO;
            juego_terminado <= 1'b0;
            linea_ganadora  <= '0;
            falta           <= 1'b0;
            movimientos     <= '0;
            indice          <= '0;
            snap            <= tablero;
`ifdef TIEMPO_LIMITE_EN
            cont_turno      <= '0;
`endif
        end else begin
            falta <= 1'b0;
            case (estado)
                ESPERA: begin
                    if (hay_mov) begin
                        snap <= tablero;
`ifdef TIEMPO_LIMITE_EN
                        cont_turno <= '0;
`endif
                        if (mov_legal) begin
                            if (movimientos != 4'd9) begin
                                movimientos <= movimientos + 4'd1;
                            end
                            estado   <= EVALUA;
                            indice   <= '0;
                            turno_p1 <= 1'b0;
                            turno_p2 <= 1'b0;
                        end else begin
                            falta <= 1'b1;
                        end
                    end
`ifdef TIEMPO_LIMITE_EN
                    else if (cont_turno == TW'(CICLOS_TURNO - 1)) begin
                        jugador_p1 <= !jugador_p1;
                        turno_p1   <= !jugador_p1;
                        turno_p2   <= jugador_p1;
                        falta      <= 1'b1;
                        cont_turno <= '0;
                    end else begin
                        cont_turno <= cont_turno + TW'(1);
                    end
`endif
                end
                EVALUA: begin
                    if (coincide) begin
                        estado          <= FIN;
                        ganador         <= codigo_linea;
                        linea_ganadora  <= indice;
                        juego_terminado <= 1'b1;
                    end else if (indice == 3'd7) begin
                        if (movimientos == 4'd9) begin
                            estado          <= FIN;
                            ganador         <= EMPATE;
                            juego_terminado <= 1'b1;
                        end else begin
                            estado     <= ESPERA;
                            jugador_p1 <= !jugador_p1;
                            turno_p1   <= !jugador_p1;
                            turno_p2   <= jugador_p1;
`ifdef TIEMPO_LIMITE_EN
                            cont_turno <= '0;
`endif
                        end
                    end else begin
                        indice <= indice + 3'd1;
                    end
                end
                FIN: begin
                    // Result held until nuevo_juego or rst
                end
                default: begin
                    estado <= ESPERA;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arbitro_turnos.sv
// Directed bench for arbitro_turnos: move table plus reset/restart/timeout sequences.
module tb_arbitro_turnos;
    import gato_pkg::*;

    localparam logic [3:0] NO = 4'd15;

    typedef struct {
        logic [3:0] ca;
        logic [3:0] cb;
        logic [1:0] cod;
        logic       legal;
        logic [1:0] gan;
        logic [2:0] lin;
    } jugada_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       nuevo_juego;
    logic [1:0] c [9];
    logic       turno_p1, turno_p2, juego_terminado, falta;
    logic [1:0] ganador;
    logic [2:0] linea_ganadora;
    logic [3:0] movimientos;

    int  n_cmp  = 0;
    int  n_fail = 0;
    bit  exp_p1;
    int  exp_mov;
    jugada_t tabla [20];

    always #5 clk = ~clk;

    arbitro_turnos #(
        .JUGADOR_INICIAL (1)
`ifdef TIEMPO_LIMITE_EN
        , .CICLOS_TURNO  (16)
`endif
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .nuevo_juego     (nuevo_juego),
        .guarda_c1       (c[0]),
        .guarda_c2       (c[1]),
        .guarda_c3       (c[2]),
        .guarda_c4       (c[3]),
        .guarda_c5       (c[4]),
        .guarda_c6       (c[5]),
        .guarda_c7       (c[6]),
        .guarda_c8       (c[7]),
        .guarda_c9       (c[8]),
        .turno_p1        (turno_p1),
        .turno_p2        (turno_p2),
        .ganador         (ganador),
        .juego_terminado (juego_terminado),
        .linea_ganadora  (linea_ganadora),
        .falta           (falta),
        .movimientos     (movimientos)
    );

    task automatic chk(input string nombre, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0d required=%0d", nombre, act, req);
        end
    endtask

    // Apply one table entry and check the response cycle by cycle
    task automatic jugar(input jugada_t j);
        int fin_esp;
        bit lineas_vistas, falta_vista, fin_antes;
        @(negedge clk);
        c[j.ca] = j.cod;
        if (j.cb != NO) c[j.cb] = j.cod;
        @(negedge clk);
        if (!j.legal) begin
            chk("falta_ilegal", 32'(falta), 1);
            chk("turno_p1_ilegal", 32'(turno_p1), 32'(exp_p1));
            chk("turno_p2_ilegal", 32'(turno_p2), 32'(!exp_p1));
            chk("mov_ilegal", 32'(movimientos), 32'(exp_mov));
            @(negedge clk);
            chk("falta_un_ciclo", 32'(falta), 0);
        end else begin
            exp_mov++;
            fin_esp = (j.gan == GANA_P1 || j.gan == GANA_P2) ? 2 + int'(j.lin) : 9;
            lineas_vistas = 0;
            falta_vista   = 0;
            fin_antes     = 0;
            for (int n = 1; n < fin_esp; n++) begin
                if (turno_p1 || turno_p2) lineas_vistas = 1;
                if (falta) falta_vista = 1;
                if (juego_terminado || ganador != NINGUNO) fin_antes = 1;
                @(negedge clk);
            end
            chk("turnos_cero_en_escaneo", 32'(lineas_vistas), 0);
            chk("sin_falta_legal", 32'(falta_vista | falta), 0);
            chk("sin_fin_temprano", 32'(fin_antes), 0);
            chk("movimientos", 32'(movimientos), 32'(exp_mov));
            if (j.gan == NINGUNO) begin
                exp_p1 = !exp_p1;
                chk("turno_p1_tras_escaneo", 32'(turno_p1), 32'(exp_p1));
                chk("turno_p2_tras_escaneo", 32'(turno_p2), 32'(!exp_p1));
                chk("sigue_juego", 32'(juego_terminado), 0);
            end else begin
                chk("ganador", 32'(ganador), 32'(j.gan));
                chk("juego_terminado", 32'(juego_terminado), 1);
                chk("turnos_cero_fin", 32'(turno_p1 | turno_p2), 0);
                if (j.gan != EMPATE) chk("linea_ganadora", 32'(linea_ganadora), 32'(j.lin));
            end
        end
    endtask

    // Restart with the selector clearing the board in the same cycle
    task automatic nuevo();
        @(negedge clk);
        for (int i = 0; i < 9; i++) c[i] = VACIA;
        nuevo_juego = 1'b1;
        @(negedge clk);
        nuevo_juego = 1'b0;
        exp_p1  = 1'b1;
        exp_mov = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int  n;
        bit  vista;
        logic [1:0] cod;

        // Game A: opening move, then illegal writes while P2 is on turn
        tabla[0]  = '{4'd4, NO,   EQUIS,   1'b1, NINGUNO, 3'd0};
        tabla[1]  = '{4'd6, NO,   EQUIS,   1'b0, NINGUNO, 3'd0};
        tabla[2]  = '{4'd6, NO,   VACIA,   1'b0, NINGUNO, 3'd0};
        tabla[3]  = '{4'd0, 4'd1, CIRCULO, 1'b0, NINGUNO, 3'd0};
        tabla[4]  = '{4'd0, 4'd1, VACIA,   1'b0, NINGUNO, 3'd0};
        tabla[5]  = '{4'd3, NO,   CIRCULO, 1'b1, NINGUNO, 3'd0};
        // Game B: P1 wins on the top row
        tabla[6]  = '{4'd0, NO,   EQUIS,   1'b1, NINGUNO, 3'd0};
        tabla[7]  = '{4'd3, NO,   CIRCULO, 1'b1, NINGUNO, 3'd0};
        tabla[8]  = '{4'd1, NO,   EQUIS,   1'b1, NINGUNO, 3'd0};
        tabla[9]  = '{4'd4, NO,   CIRCULO, 1'b1, NINGUNO, 3'd0};
        tabla[10] = '{4'd2, NO,   EQUIS,   1'b1, GANA_P1, 3'd0};
        // Game C: nine moves, no line -> draw
        tabla[11] = '{4'd0, NO,   EQUIS,   1'b1, NINGUNO, 3'd0};
        tabla[12] = '{4'd1, NO,   CIRCULO, 1'b1, NINGUNO, 3'd0};
        tabla[13] = '{4'd2, NO,   EQUIS,   1'b1, NINGUNO, 3'd0};
        tabla[14] = '{4'd4, NO,   CIRCULO, 1'b1, NINGUNO, 3'd0};
        tabla[15] = '{4'd3, NO,   EQUIS,   1'b1, NINGUNO, 3'd0};
        tabla[16] = '{4'd5, NO,   CIRCULO, 1'b1, NINGUNO, 3'd0};
        tabla[17] = '{4'd7, NO,   EQUIS,   1'b1, NINGUNO, 3'd0};
        tabla[18] = '{4'd6, NO,   CIRCULO, 1'b1, NINGUNO, 3'd0};
        tabla[19] = '{4'd8, NO,   EQUIS,   1'b1, EMPATE,  3'd0};

        rst = 1'b1;
        nuevo_juego = 1'b0;
        for (int i = 0; i < 9; i++) c[i] = VACIA;
        exp_p1  = 1'b1;
        exp_mov = 0;
        repeat (2) @(negedge clk);
        chk("rst_turno_p1", 32'(turno_p1), 1);
        chk("rst_turno_p2", 32'(turno_p2), 0);
        chk("rst_ganador", 32'(ganador), 32'(NINGUNO));
        chk("rst_terminado", 32'(juego_terminado), 0);
        chk("rst_linea", 32'(linea_ganadora), 0);
        chk("rst_falta", 32'(falta), 0);
        chk("rst_mov", 32'(movimientos), 0);
        rst = 1'b0;

        for (int i = 0; i <= 5; i++) jugar(tabla[i]);
        nuevo();
        for (int i = 6; i <= 10; i++) jugar(tabla[i]);

        // FIN ignores board changes and holds the result
        c[8] = CIRCULO;
        vista = 0;
        repeat (4) begin
            @(negedge clk);
            if (falta) vista = 1;
        end
        chk("fin_sin_falta", 32'(vista), 0);
        chk("fin_ganador", 32'(ganador), 32'(GANA_P1));
        chk("fin_terminado", 32'(juego_terminado), 1);
        chk("fin_mov", 32'(movimientos), 5);

        nuevo();
        chk("nuevo_ganador", 32'(ganador), 32'(NINGUNO));
        chk("nuevo_terminado", 32'(juego_terminado), 0);
        chk("nuevo_turno_p1", 32'(turno_p1), 1);
        chk("nuevo_mov", 32'(movimientos), 0);
        for (int i = 11; i <= 19; i++) jugar(tabla[i]);
        nuevo();

`ifdef TIEMPO_LIMITE_EN
        n = 0;
        while (!falta && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_ciclos", 32'(n), 16);
        chk("timeout_turno_p1", 32'(turno_p1), 0);
        chk("timeout_turno_p2", 32'(turno_p2), 1);
        chk("timeout_mov", 32'(movimientos), 0);
        @(negedge clk);
        chk("timeout_falta_un_ciclo", 32'(falta), 0);
        exp_p1 = 1'b0;
`else
        vista = 0;
        repeat (20) begin
            @(negedge clk);
            if (falta) vista = 1;
        end
        chk("espera_sin_limite_falta", 32'(vista), 0);
        chk("espera_sin_limite_turno", 32'(turno_p1), 1);
`endif

        // Reset in the middle of a scan
        cod = exp_p1 ? EQUIS : CIRCULO;
        c[4] = cod;
        repeat (4) @(negedge clk);
        chk("escaneo_en_curso", 32'(turno_p1 | turno_p2), 0);
        rst = 1'b1;
        #1;
        chk("rst_async_turno_p1", 32'(turno_p1), 1);
        chk("rst_async_turno_p2", 32'(turno_p2), 0);
        chk("rst_async_mov", 32'(movimientos), 0);
        chk("rst_async_ganador", 32'(ganador), 32'(NINGUNO));
        for (int i = 0; i < 9; i++) c[i] = VACIA;
        @(negedge clk);
        rst = 1'b0;
        vista = 0;
        repeat (10) begin
            @(negedge clk);
            if (falta || turno_p2 || !turno_p1) vista = 1;
        end
        chk("rst_sin_residuo", 32'(vista), 0);
        chk("rst_sin_residuo_mov", 32'(movimientos), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
